regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath and write-data width.
REQ-002 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports, per requester i in {0=ALU, 1=LSU, 2=MUL}: req_valid_i  input  1; req_rd_i  input  5; req_data_i  input  XLEN; req_ready_i  output  1.
REQ-005 SHALL have ports: resv_valid  input  1  reserve destination; resv_rd  input  5  register being reserved.
REQ-006 SHALL have ports: wb_we  output  1; wb_sel  output  5; wb_data  output  XLEN -- drive register-bank we/sel_in/data_in.
REQ-007 SHALL have port: busy  output  32  pending-write scoreboard, bit n = xn has an outstanding write.

Function
REQ-008 SHALL grant at most one requester per cycle; req_ready_i combinational, high only for the granted requester with req_valid_i high.
REQ-009 SHALL treat req_valid_i & req_ready_i as a transfer; an ungranted requester SHALL hold valid, rd and data stable until granted.
REQ-010 SHALL register the transferred rd/data into wb_sel/wb_data and assert wb_we in the following cycle (latency 1 cycle).
REQ-011 SHALL deassert wb_we in any cycle following one with no transfer; wb_sel/wb_data hold last value.
REQ-012 SHALL accept a transfer with rd = 0 (ready asserted) but SHALL keep wb_we = 0 for it.
REQ-013 SHALL set busy[resv_rd] at the clock edge where resv_valid = 1 and resv_rd != 0.
REQ-014 SHALL clear busy[wb_sel] at the clock edge ending a cycle with wb_we = 1.
REQ-015 SHALL, when set and clear target the same register in the same cycle, leave that bit 1 (set wins).
REQ-016 SHALL hold busy[0] at 0 permanently.
REQ-017 SHALL not check busy before granting; scoreboard is advisory to decode stall logic.

Reset
REQ-018 SHALL, while reset = 0, force wb_we = 0, wb_sel = 0, wb_data = 0, busy = 0, arbitration pointer = 2, regardless of clock.
REQ-019 SHALL drive all req_ready_i = 0 while reset = 0.
REQ-020 SHALL discard any transfer in flight when reset asserts; no write SHALL appear after reset release without a new transfer.

Configuration
REQ-021 SHALL, with macro WB_ROUND_ROBIN_EN defined, arbitrate round-robin: search starts at (last granted + 1) mod 3; pointer updates only on a transfer.
REQ-022 SHALL, without WB_ROUND_ROBIN_EN, arbitrate fixed priority ALU > LSU > MUL and keep no pointer state.

Verification
REQ-023 SHALL cover: single ALU transfer rd=5 data=0xDEADBEEF -> cycle+1 wb_we=1, wb_sel=5, wb_data=0xDEADBEEF; cycle+2 wb_we=0.
REQ-024 SHALL cover: all three valid continuously (rd=1,2,3), WB_ROUND_ROBIN_EN -> grants ALU, LSU, MUL, ALU; without macro -> ALU every cycle, others stalled with stable data.
REQ-025 SHALL cover: LSU transfer rd=0 data=0x1234 -> req_ready_1=1, wb_we stays 0, busy unchanged.
REQ-026 SHALL cover: resv rd=7, later MUL write rd=7 -> busy[7]=1 after reserve edge, 0 after edge ending wb_we cycle; reserve rd=7 in that same cycle -> busy[7] stays 1.
REQ-027 SHALL cover: reset=0 asserted mid-cycle with wb_we=1 and busy=0x0000_0080 -> immediately wb_we=0, busy=0, ready=0; after release, first grant with all valid is ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for three requesters (ALU, LSU, MUL) feeding a register bank, with a pending-write scoreboard.
// Build macro WB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority ALU > LSU > MUL.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid_0,
  input  logic [4:0]      req_rd_0,
  input  logic [XLEN-1:0] req_data_0,
  output logic            req_ready_0,
  input  logic            req_valid_1,
  input  logic [4:0]      req_rd_1,
  input  logic [XLEN-1:0] req_data_1,
  output logic            req_ready_1,
  input  logic            req_valid_2,
  input  logic [4:0]      req_rd_2,
  input  logic [XLEN-1:0] req_data_2,
  output logic            req_ready_2,
  input  logic            resv_valid,
  input  logic [4:0]      resv_rd,
  output logic            wb_we,
  output logic [4:0]      wb_sel,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     busy
);

  logic [2:0]      valid_s;
  logic [2:0]      grant_s;
  logic            xfer_s;
  logic [4:0]      xfer_rd_s;
  logic [XLEN-1:0] xfer_data_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     busy_next_s;

  assign valid_s = {req_valid_2, req_valid_1, req_valid_0};

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] last_r;

  // Round-robin grant: search begins one past the last granted requester; nothing granted in reset.
  always_comb begin
    grant_s = 3'b000;
    if (reset) begin
      case (last_r)
        2'd0: begin
          if (valid_s[1])      grant_s = 3'b010;
          else if (valid_s[2]) grant_s = 3'b100;
          else if (valid_s[0]) grant_s = 3'b001;
          else                 grant_s = 3'b000;
        end
        2'd1: begin
          if (valid_s[2])      grant_s = 3'b100;
          else if (valid_s[0]) grant_s = 3'b001;
          else if (valid_s[1]) grant_s = 3'b010;
          else                 grant_s = 3'b000;
        end
        default: begin
          if (valid_s[0])      grant_s = 3'b001;
          else if (valid_s[1]) grant_s = 3'b010;
          else if (valid_s[2]) grant_s = 3'b100;
          else                 grant_s = 3'b000;
        end
      endcase
    end else begin
      grant_s = 3'b000;
    end
  end

  // Last-granted pointer; moves only on a transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_r <= 2'd2;
    end else if (xfer_s) begin
      if (grant_s[0])      last_r <= 2'd0;
      else if (grant_s[1]) last_r <= 2'd1;
      else                 last_r <= 2'd2;
    end else begin
      last_r <= last_r;
    end
  end
`else
  // Fixed-priority grant ALU > LSU > MUL; nothing granted in reset.
  always_comb begin
    grant_s = 3'b000;
    if (!reset)          grant_s = 3'b000;
    else if (valid_s[0]) grant_s = 3'b001;
    else if (valid_s[1]) grant_s = 3'b010;
    else if (valid_s[2]) grant_s = 3'b100;
    else                 grant_s = 3'b000;
  end
`endif

  assign req_ready_0 = grant_s[0];
  assign req_ready_1 = grant_s[1];
  assign req_ready_2 = grant_s[2];
  assign xfer_s      = |grant_s;

  // Steer the granted requester's destination and data.
  always_comb begin
    xfer_rd_s   = 5'd0;
    xfer_data_s = {XLEN{1'b0}};
    case (grant_s)
      3'b001: begin
        xfer_rd_s   = req_rd_0;
        xfer_data_s = req_data_0;
      end
      3'b010: begin
        xfer_rd_s   = req_rd_1;
        xfer_data_s = req_data_1;
      end
      3'b100: begin
        xfer_rd_s   = req_rd_2;
        xfer_data_s = req_data_2;
      end
      default: begin
        xfer_rd_s   = 5'd0;
        xfer_data_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Write-back stage: x0 transfers are accepted but never raise the write enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_we   <= 1'b0;
      wb_sel  <= 5'd0;
      wb_data <= {XLEN{1'b0}};
    end else if (xfer_s) begin
      wb_we   <= (xfer_rd_s != 5'd0);
      wb_sel  <= xfer_rd_s;
      wb_data <= xfer_data_s;
    end else begin
      wb_we   <= 1'b0;
      wb_sel  <= wb_sel;
      wb_data <= wb_data;
    end
  end

  // Scoreboard update: a same-cycle reserve overrides the retiring write; x0 never tracked.
  always_comb begin
    set_mask_s  = (resv_valid && (resv_rd != 5'd0)) ? (32'd1 << resv_rd) : 32'd0;
    clr_mask_s  = wb_we ? (32'd1 << wb_sel) : 32'd0;
    busy_next_s = ((busy & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Scoreboard register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next_s;
    end
  end

endmodule
